// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-word pipeline from ID through STAGES registers.
// Each stage keeps only the fields its mask allows. The block supports
// bubble insertion, stall and flush, and has retire/bubble counters.
module ctrl_pipe #(
   parameter int unsigned                  CTRL_W      = 16,
   parameter int unsigned                  STAGES      = 3,
   parameter logic [STAGES*CTRL_W-1:0]     STAGE_MASK  = '1,
   parameter int unsigned                  FLUSH_DEPTH = 1,
   parameter int unsigned                  CNT_W       = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [CTRL_W-1:0]               ctrl_in,
   input  logic                            valid_in,
   input  logic                            bubble,
   input  logic                            stall,
   input  logic                            flush,
   output logic [STAGES*CTRL_W-1:0]        stage_ctrl,
   output logic [STAGES-1:0]               stage_valid,
   output logic                            retire_pulse,
   output logic [$clog2(STAGES+1)-1:0]     occupancy,
   output logic [CNT_W-1:0]                retire_cnt,
   output logic [CNT_W-1:0]                bubble_cnt
);

   localparam int unsigned OCC_W = $clog2(STAGES+1);

   logic [STAGES-1:0][CTRL_W-1:0] ctrl_q, ctrl_d, src_ctrl;
   logic [STAGES-1:0]             valid_q, valid_d, src_valid;

   // Next-state for every stage. src_* is the word that would be loaded on
   // advance: ID entry for stage 0, otherwise the upstream stage. A flushed
   // upstream stage hands over a zero word, because flush clears it first.
   always_comb begin
      src_ctrl  = '0;
      src_valid = '0;
      ctrl_d    = ctrl_q;
      valid_d   = valid_q;

      src_valid[0] = valid_in & ~bubble;
      src_ctrl[0]  = src_valid[0] ? ctrl_in : '0;
      for (int unsigned k = 1; k < STAGES; k++) begin
         if (!(flush && (k <= FLUSH_DEPTH))) begin
            src_ctrl[k]  = ctrl_q[k-1];
            src_valid[k] = valid_q[k-1];
         end
      end

      for (int unsigned k = 0; k < STAGES; k++) begin
         if (flush && (k < FLUSH_DEPTH)) begin
            ctrl_d[k]  = '0;
            valid_d[k] = 1'b0;
         end else if (!stall) begin
            ctrl_d[k]  = src_ctrl[k] & STAGE_MASK[k*CTRL_W +: CTRL_W];
            valid_d[k] = src_valid[k];
         end
      end
   end

   // Stage registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q  <= '0;
         valid_q <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
      end
   end

   // Retire and bubble counters. They hold during stall and wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         retire_cnt <= '0;
         bubble_cnt <= '0;
      end else begin
         if (retire_pulse)
            retire_cnt <= retire_cnt + CNT_W'(1);
         if (!stall && (bubble || !valid_in))
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

   // Occupancy is the number of valid stages.
   always_comb begin
      occupancy = '0;
      for (int unsigned k = 0; k < STAGES; k++)
         occupancy = occupancy + OCC_W'(valid_q[k]);
   end

   assign stage_ctrl   = ctrl_q;
   assign stage_valid  = valid_q;
   assign retire_pulse = valid_q[STAGES-1] & ~stall;

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised control-signal pipeline for the pipelined processing unit. It carries the control unit's decoded control word from ID through STAGES downstream pipeline registers (EX, MEM, WB by default), with three features:
- a per-stage field mask, so each stage keeps only the fields it consumes;
- bubble (NOP) insertion, stall and flush;
- retirement and bubble counters for debug and performance monitoring.

It replaces the hand-instantiated control-unit mux and per-stage control registers with one configurable block.

## Interface
Parameters:
- CTRL_W, 16, width of one control word (AM, RF_EN, ALU_OP, S, DATAMEM_EN, R/W, SIZE, LOAD, ... packed by the integrator).
- STAGES, 3, number of pipeline registers after ID; legal range 1..8.
- STAGE_MASK, all ones ({STAGES*CTRL_W}), per-stage keep mask. Slice k = bits [k*CTRL_W +: CTRL_W]. A 0 bit forces that field to 0 in stage k.
- FLUSH_DEPTH, 1, number of youngest stages (0..FLUSH_DEPTH-1) cleared by flush; legal range 0..STAGES.
- CNT_W, 16, counter width.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high.
- ctrl_in  in  CTRL_W  control word from the control unit (ID stage).
- valid_in  in  1  ctrl_in carries a real instruction.
- bubble  in  1  replace ctrl_in with a NOP this cycle (the cuMux select function).
- stall  in  1  freeze all stages.
- flush  in  1  clear stages 0..FLUSH_DEPTH-1.
- stage_ctrl  out  STAGES*CTRL_W  registered control word per stage; slice k is stage k (0 = EX).
- stage_valid  out  STAGES  registered valid per stage.
- retire_pulse  out  1  combinational: stage_valid[STAGES-1] & ~stall.
- occupancy  out  $clog2(STAGES+1)  combinational popcount of stage_valid.
- retire_cnt  out  CNT_W  number of retired instructions.
- bubble_cnt  out  CNT_W  number of bubbles inserted.

## Operation
- Stage 0 entry word:
  - ctrl_in & mask0 when valid_in & ~bubble;
  - otherwise 0 with valid 0. This is a NOP, and a NOP always has all-zero ctrl.
- Stage k>0 advance: takes stage k-1's word & maskk and stage k-1's valid.
- Update priority per stage, highest first:
  1. reset;
  2. flush (for stages < FLUSH_DEPTH);
  3. stall (hold);
  4. advance.
- Flush and stall together: flushed stages clear; unflushed stages hold.
- Flush without stall: unflushed stages advance normally. Stage FLUSH_DEPTH receives a zero word from the flushed stage FLUSH_DEPTH-1, because flush overrides its contents before transfer.
- A stage whose valid is 0 holds an all-zero ctrl word at all times.
- retire_cnt increments by 1 on each cycle where retire_pulse=1. It wraps modulo 2^CNT_W.
- bubble_cnt increments on each cycle where ~stall & ~reset & (bubble | ~valid_in). It wraps modulo 2^CNT_W.
- While stall=1 the counters hold. Flush does not change the counters.

## Timing
- Reset, sampled on a rising clk edge, forces on that edge:
  - stage_ctrl=0, stage_valid=0, retire_cnt=0, bubble_cnt=0;
  - and therefore retire_pulse=0 and occupancy=0.
- Reset mid-stream discards all in-flight words in the same edge, with no retirement counted.
- Latency: a word accepted at edge n appears at stage k after edge n+k (stage 0 at edge n). This assumes no stall.
- stall has effect on the edge where it is sampled high. Inputs presented during a stalled cycle are dropped; the upstream holds IF/ID.
- bubble, valid_in, stall and flush are sampled at the same edge. There are no multi-cycle handshakes.

## Test plan
- Stream: STAGES=3, CTRL_W=16, masks all ones. Apply reset for 1 edge, then ctrl_in=16'hA001, 16'hA002, 16'hA003, 16'hA004 with valid_in=1 on consecutive edges.
  - Required: 16'hA001 appears in stage 2 after its 3rd edge.
  - Required: retire_pulse is high for 4 consecutive cycles starting when stage_valid[2] first goes high; after that retire_cnt=4.
- Masking: STAGE_MASK slice 2 = 16'h00FF, ctrl_in=16'hBEEF.
  - Required: stage 0=BEEF, stage 1=BEEF, stage 2=00EF.
- Bubble: bubble=1 for 2 cycles mid-stream.
  - Required: 2 zero words with valid=0 travel the pipe, bubble_cnt +=2, and retire_cnt does not count them.
- Stall plus flush: pipe full (occupancy=3), FLUSH_DEPTH=1, assert stall=1 and flush=1 for one edge.
  - Required: stage 0 becomes 0 and valid 0; stages 1 and 2 hold; occupancy=2; no counter changes.
- Reset mid-operation: with the pipe full and retire_cnt=5, pulse reset.
  - Required: all outputs are 0 on the next edge and no retire_pulse follows.
- Wrap: CNT_W=4, retire 17 instructions.
  - Required: retire_cnt=1.
